gate_response_checker: RTL and testbench

Self-checking hardware exerciser for any 2-input logic gate in the switch-level library. It drives the exhaustive input sweep 00, 01, 10, 11 onto the gate under test. After a programmable settle window it samples the gate output and compares it against a parameterised truth table. It accumulates a mismatch count, captures the first failing vector, and reports pass/fail, so gate models can be checked in-circuit rather than by reading a monitor log.

---
 rtl/gate_check_pkg.sv | 20 ++
 rtl/gate_settle_timer.sv | 35 +++
 rtl/gate_response_checker.sv | 140 ++++++++++++++
 tb/tb_gate_response_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate response exercisers.
// Truth tables are indexed by {a,b}.
package gate_check_pkg;

  localparam int VEC_W = 2;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_FINISH
  } state_e;

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable down-counter with a zero flag.
// Holds at zero until reloaded.
module gate_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps a 2-input gate through 00..11, samples y after a settle
// window and scores it against TRUTH_TABLE.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_NAND,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         PASSES        = 1,
  parameter int         ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW = $clog2(PASSES) + 1;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               ffv_q, ffv_d;
  logic [VEC_W-1:0]   ffvec_q, ffvec_d;
  logic               pass_q, pass_d;
  logic               y_q;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic               mismatch, last;

  gate_settle_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (CW'(SETTLE_CYCLES)),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Case-inequality so an X/Z response is scored as a failure.
  assign mismatch = (y_q !== TRUTH_TABLE[vec_q]);
  assign last     = (vec_q == '1) && (pcnt_q == PW'(PASSES - 1));

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    pcnt_d   = pcnt_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_APPLY;
          vec_d    = '0;
          pcnt_d   = '0;
          err_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
          pass_d   = 1'b0;
          tmr_load = 1'b1;
        end
      end
      S_APPLY: begin
        if (tmr_zero) state_d = S_SAMPLE;
        else          tmr_dec = 1'b1;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        if (last) begin
          state_d = S_FINISH;
          pass_d  = !(ffv_q || mismatch);
        end else begin
          state_d  = S_APPLY;
          vec_d    = vec_q + 1'b1;
          tmr_load = 1'b1;
          if (vec_q == '1) pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      pcnt_q  <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      pass_q  <= pass_d;
    end
  end

  // y is registered on the last settle edge; scoring uses the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 1'b0;
    end else if ((state_q == S_APPLY) && tmr_zero) begin
      y_q <= y;
    end
  end

  assign a                = vec_q[1];
  assign b                = vec_q[0];
  assign busy             = (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign done             = (state_q == S_FINISH);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: directed runs plus random
// starts/gates checked against a run-level reference model.
module tb_gate_response_checker;
  import gate_check_pkg::*;

  localparam int S   = 2;
  localparam int P   = 1;
  localparam int RUN = 4 * P * (S + 2);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       a, b, y;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic       ffv;
  logic [1:0] ffvec;
  logic [3:0] gate_tt;

  logic       start2;
  logic       a2, b2, y2;
  logic       busy2, done2, pass2;
  logic [1:0] err2;
  logic       ffv2;
  logic [1:0] ffvec2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign y  = gate_tt[{a, b}];
  assign y2 = a2 & b2;

  gate_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count),
    .first_fail_valid(ffv),
    .first_fail_vec(ffvec)
  );

  gate_response_checker #(
    .TRUTH_TABLE(TT_NAND), .SETTLE_CYCLES(2),
    .PASSES(2), .ERR_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a(a2), .b(b2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2),
    .first_fail_valid(ffv2),
    .first_fail_vec(ffvec2)
  );

  // Reference model: run timeline and results per accepted start.
  logic       m_run;
  int         m_t;
  logic [1:0] m_vec;
  int         m_err, p_err;
  logic       m_ffv, p_ffv;
  logic [1:0] m_fvec, p_fvec;
  logic       m_pass, p_pass;

  function automatic int score(input logic [3:0] tt);
    int n = 0;
    for (int i = 0; i < 4; i++) if (tt[i] != TT_NAND[i]) n++;
    n = n * P;
    return (n > 255) ? 255 : n;
  endfunction

  function automatic logic [1:0] first_bad(input logic [3:0] tt);
    for (int i = 3; i >= 0; i--)
      if (tt[i] != TT_NAND[i]) first_bad = 2'(i);
    if (tt == TT_NAND) first_bad = 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_t <= 0; m_vec <= 2'b00;
      m_err <= 0; m_ffv <= 1'b0; m_fvec <= 2'b00; m_pass <= 1'b0;
      p_err <= 0; p_ffv <= 1'b0; p_fvec <= 2'b00; p_pass <= 1'b0;
    end else if (m_run) begin
      m_t <= m_t + 1;
      if (m_t + 1 < RUN) m_vec <= 2'(((m_t + 1) / (S + 2)) % 4);
      if (m_t + 1 == RUN) begin
        m_err <= p_err; m_ffv <= p_ffv;
        m_fvec <= p_fvec; m_pass <= p_pass;
      end
      if (m_t + 1 > RUN) m_run <= 1'b0;
    end else if (start) begin
      m_run <= 1'b1; m_t <= 0; m_vec <= 2'b00;
      m_err <= 0; m_ffv <= 1'b0; m_fvec <= 2'b00; m_pass <= 1'b0;
      p_err  <= score(gate_tt);
      p_ffv  <= (gate_tt != TT_NAND);
      p_fvec <= first_bad(gate_tt);
      p_pass <= (gate_tt == TT_NAND);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic eb;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        eb = m_run && (m_t < RUN);
        chk("busy", 32'(busy), 32'(eb));
        chk("done", 32'(done), 32'(m_run && (m_t == RUN)));
        chk("ab", 32'({a, b}), 32'(m_vec));
        if (!eb) begin
          chk("err_count", 32'(err_count), 32'(m_err));
          chk("ff_valid", 32'(ffv), 32'(m_ffv));
          chk("ff_vec", 32'(ffvec), 32'(m_fvec));
          chk("pass", 32'(pass), 32'(m_pass));
        end else begin
          chk("pass_run", 32'(pass), 32'd0);
        end
      end
    end
  endtask

  task automatic run1(input logic [3:0] tt, input bit extra,
                      output int lat);
    @(negedge clk);
    gate_tt = tt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 80) begin
      @(negedge clk);
      lat++;
      start = extra && (lat == 2 || lat == 9);
    end
    start = 1'b0;
  endtask

  task automatic results(input string nm, input int e,
                         input logic v, input logic [1:0] fv,
                         input logic p);
    chk({nm, "_err"}, 32'(err_count), 32'(e));
    chk({nm, "_ffv"}, 32'(ffv), 32'(v));
    chk({nm, "_ffvec"}, 32'(ffvec), 32'(fv));
    chk({nm, "_pass"}, 32'(pass), 32'(p));
  endtask

  initial begin
    int lat, nd;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; gate_tt = TT_NAND;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    #2 rst_n = 1'b1;
    fork monitor(); join_none

    run1(TT_NAND, 1'b0, lat);
    chk("nand_latency", 32'(lat), 32'd16);
    results("nand", 0, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);

    run1(TT_AND, 1'b1, lat);
    chk("and_latency", 32'(lat), 32'd16);
    results("and", 4, 1'b1, 2'b00, 1'b0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("ignored_starts", 32'(nd), 32'd0);

    gate_tt = TT_NAND;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_clear", 32'(err_count), 32'd0);
    repeat (20) @(negedge clk);

    run1(4'b1111, 1'b0, lat);
    results("stuck1", 1, 1'b1, 2'b11, 1'b0);

    @(negedge clk);
    gate_tt = TT_AND;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ab", 32'({a, b}), 32'd0);
    chk("arst_all", 32'({done, pass, err_count, ffv, ffvec}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run1(TT_NAND, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd16);
    results("post_rst", 0, 1'b0, 2'b00, 1'b1);

    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk("sat_latency", 32'(lat), 32'd32);
    chk("sat_err", 32'(err2), 32'd3);
    chk("sat_ffv", 32'(ffv2), 32'd1);
    chk("sat_ffvec", 32'(ffvec2), 32'd0);
    chk("sat_pass", 32'(pass2), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!m_run && ($urandom % 3 == 0)) begin
        case ($urandom % 4)
          0: gate_tt = TT_NAND;
          1: gate_tt = TT_AND;
          2: gate_tt = 4'b1111;
          default: gate_tt = 4'($urandom);
        endcase
      end
      start = ($urandom % 4 == 0);
    end
    start = 1'b0;
    repeat (25) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
